// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared state type, sizing constants and channel-scan helper for adc_sequencer
package adc_seq_pkg;

    localparam int NBITS_MAX = 16;
    localparam int MUX_W     = 4;
    localparam int NUM_ADC   = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_SAMP  = 3'd2,
        S_CMP   = 3'd3,
        S_LOGIC = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Next enabled channel strictly after cur, wrapping; an empty mask means channel 0 only.
    // Scanning from the farthest offset down to the nearest lets the nearest hit win.
    function automatic logic [MUX_W-1:0] next_chan(input logic [NUM_ADC-1:0] mask,
                                                   input logic [MUX_W-1:0]   cur);
        logic [NUM_ADC-1:0] m;
        logic [MUX_W-1:0]   idx;
        logic [MUX_W-1:0]   sel;
        m   = (mask == '0) ? NUM_ADC'(1) : mask;
        sel = cur;
        for (int i = NUM_ADC; i >= 1; i--) begin
            idx = cur + i[MUX_W-1:0];
            if (m[idx]) begin
                sel = idx;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/seq_phase_timer.sv
// rtl/seq_phase_timer.sv - loadable down-counter timing every sequencer phase
module seq_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load_i,
    input  logic [CNT_W-1:0] dur_i,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on phase entry (a zero duration reads as one cycle), otherwise count down and park at 1
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (dur_i == '0) ? CNT_W'(1) : dur_i;
        end else if (cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count holds the cycles remaining in the phase, including the current one
    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/adc_sequencer.sv
// rtl/adc_sequencer.sv - SAR ADC conversion sequencer with result handshake; optional channel autoscan under ADC_SEQ_AUTOSCAN_EN
module adc_sequencer #(
    parameter int CNT_W     = 8,
    parameter int NBITS_MAX = adc_seq_pkg::NBITS_MAX
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     t_init,
    input  logic [CNT_W-1:0]     t_samp,
    input  logic [CNT_W-1:0]     t_cmp,
    input  logic [CNT_W-1:0]     t_logic,
    input  logic [4:0]           n_bits,
    input  logic                 comp_in,
    output logic                 seq_init,
    output logic                 seq_samp,
    output logic                 seq_cmp,
    output logic                 seq_logic,
    output logic                 busy,
    output logic [NBITS_MAX-1:0] result,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 overrun,
`ifdef ADC_SEQ_AUTOSCAN_EN
    input  logic [15:0]          adc_mask,
    output logic [3:0]           mux_sel,
    output logic [3:0]           result_chan,
`endif
    input  logic                 clr_overrun
);

    import adc_seq_pkg::*;

    localparam logic [4:0] NB_MAX5 = 5'(NBITS_MAX);

    state_t               state_q, state_d;
    logic [4:0]           bit_q, bit_d;
    logic [NBITS_MAX-1:0] acc_q, acc_d;
    logic [NBITS_MAX-1:0] result_q, result_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic                 seq_init_q, seq_samp_q, seq_cmp_q, seq_logic_q, busy_q;

    logic [CNT_W-1:0]     t_samp_q, t_cmp_q, t_logic_q;
    logic [4:0]           n_eff_q;
    logic [4:0]           n_eff_in;

    logic                 start_conv;
    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_dur;
    logic                 tmr_last;

    assign n_eff_in = ((n_bits == 5'd0) || (n_bits > NB_MAX5)) ? NB_MAX5 : n_bits;

    // Next-state, bit capture and phase-timer load decode
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        acc_d   = acc_q;
        tmr_dur = t_init;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                if (tmr_last) begin
                    state_d = S_SAMP;
                end
            end
            S_SAMP: begin
                if (tmr_last) begin
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (tmr_last) begin
                    acc_d   = {acc_q[NBITS_MAX-2:0], comp_in};
                    state_d = S_LOGIC;
                end
            end
            S_LOGIC: begin
                if (tmr_last) begin
                    if (bit_q < (n_eff_q - 5'd1)) begin
                        bit_d   = bit_q + 5'd1;
                        state_d = S_CMP;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = continuous ? S_INIT : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
        end

        // A new conversion clears the shift register so unused upper bits read as zero
        start_conv = (state_d == S_INIT) && (state_q != S_INIT);
        if (start_conv) begin
            bit_d = 5'd0;
            acc_d = '0;
        end

        // Phases always alternate, so any state change is a phase entry. INIT takes the
        // live t_init because the latched copies are only being captured this cycle.
        tmr_load = (state_d != state_q);
        case (state_d)
            S_INIT:  tmr_dur = t_init;
            S_SAMP:  tmr_dur = t_samp_q;
            S_CMP:   tmr_dur = t_cmp_q;
            S_LOGIC: tmr_dur = t_logic_q;
            default: tmr_dur = t_init;
        endcase
    end

    // Result register, valid/ready handshake and sticky overrun
    always_comb begin
        result_d  = result_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (valid_q && result_ready) begin
            valid_d = 1'b0;
        end
        if (clr_overrun) begin
            overrun_d = 1'b0;
        end
        if ((state_q == S_DONE) && !abort) begin
            result_d = acc_q;
            valid_d  = 1'b1;
            if (valid_q && !result_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    // State, datapath and phase outputs; outputs are decoded from the next state so they are registered
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q     <= S_IDLE;
            bit_q       <= 5'd0;
            acc_q       <= '0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            seq_init_q  <= 1'b0;
            seq_samp_q  <= 1'b0;
            seq_cmp_q   <= 1'b0;
            seq_logic_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            seq_init_q  <= (state_d == S_INIT);
            seq_samp_q  <= (state_d == S_SAMP);
            seq_cmp_q   <= (state_d == S_CMP);
            seq_logic_q <= (state_d == S_LOGIC);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    // Conversion settings are frozen on entry to INIT
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            t_samp_q  <= '0;
            t_cmp_q   <= '0;
            t_logic_q <= '0;
            n_eff_q   <= NB_MAX5;
        end else if (start_conv) begin
            t_samp_q  <= t_samp;
            t_cmp_q   <= t_cmp;
            t_logic_q <= t_logic;
            n_eff_q   <= n_eff_in;
        end
    end

    seq_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_b  (rst_b),
        .load_i (tmr_load),
        .dur_i  (tmr_dur),
        .last_o (tmr_last)
    );

    assign seq_init     = seq_init_q;
    assign seq_samp     = seq_samp_q;
    assign seq_cmp      = seq_cmp_q;
    assign seq_logic    = seq_logic_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign overrun      = overrun_q;

`ifdef ADC_SEQ_AUTOSCAN_EN
    logic [MUX_W-1:0] mux_sel_q, mux_sel_d;
    logic [MUX_W-1:0] chan_q, chan_d;

    // Channel selection moves only when leaving IDLE or in a completed DONE
    always_comb begin
        mux_sel_d = mux_sel_q;
        chan_d    = chan_q;
        if ((state_q == S_IDLE) && (state_d == S_INIT)) begin
            mux_sel_d = next_chan(adc_mask, MUX_W'(NUM_ADC - 1));
        end else if ((state_q == S_DONE) && !abort) begin
            chan_d    = mux_sel_q;
            mux_sel_d = next_chan(adc_mask, mux_sel_q);
        end
    end

    // Autoscan registers
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            mux_sel_q <= '0;
            chan_q    <= '0;
        end else begin
            mux_sel_q <= mux_sel_d;
            chan_q    <= chan_d;
        end
    end

    assign mux_sel     = mux_sel_q;
    assign result_chan = chan_q;
`endif

endmodule

// File: tb/tb_adc_sequencer.sv
// tb/tb_adc_sequencer.sv - directed self-checking bench for adc_sequencer
module tb_adc_sequencer;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        start;
    logic        continuous;
    logic        abort;
    logic [7:0]  t_init, t_samp, t_cmp, t_logic;
    logic [4:0]  n_bits;
    logic        comp_in;
    logic        seq_init, seq_samp, seq_cmp, seq_logic, busy;
    logic [15:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        overrun;
    logic        clr_overrun;
`ifdef ADC_SEQ_AUTOSCAN_EN
    logic [15:0] adc_mask;
    logic [3:0]  mux_sel;
    logic [3:0]  result_chan;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    adc_sequencer dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .start        (start),
        .continuous   (continuous),
        .abort        (abort),
        .t_init       (t_init),
        .t_samp       (t_samp),
        .t_cmp        (t_cmp),
        .t_logic      (t_logic),
        .n_bits       (n_bits),
        .comp_in      (comp_in),
        .seq_init     (seq_init),
        .seq_samp     (seq_samp),
        .seq_cmp      (seq_cmp),
        .seq_logic    (seq_logic),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overrun      (overrun),
`ifdef ADC_SEQ_AUTOSCAN_EN
        .adc_mask     (adc_mask),
        .mux_sel      (mux_sel),
        .result_chan  (result_chan),
`endif
        .clr_overrun  (clr_overrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic set_std();
        t_init = 8'd2; t_samp = 8'd3; t_cmp = 8'd1; t_logic = 8'd1; n_bits = 5'd4;
    endtask

    // Start pulse then run to cycle 16 (idle again); optionally raise clr_overrun only in DONE
    task automatic run_std(input logic cbit, input logic clr_at_done);
        set_std();
        comp_in = cbit;
        start = 1'b1; cyc = 0; step(); start = 1'b0;
        for (int k = 0; k < 15; k++) begin
            clr_overrun = (cyc == 14) ? clr_at_done : 1'b0;
            step();
        end
        clr_overrun = 1'b0;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0; comp_in = 1'b0;
        result_ready = 1'b0; clr_overrun = 1'b0;
        set_std();
`ifdef ADC_SEQ_AUTOSCAN_EN
        adc_mask = 16'h0000;
`endif
        step(); step(); step();
        n_cmp++; if ({seq_init, seq_samp, seq_cmp, seq_logic} !== 4'b0000) begin n_fail++; $display("FAIL reset_seq: got %b expected 0000", {seq_init, seq_samp, seq_cmp, seq_logic}); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result: got %h expected 0000", result); end
        n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
`ifdef ADC_SEQ_AUTOSCAN_EN
        n_cmp++; if ({mux_sel, result_chan} !== 8'h00) begin n_fail++; $display("FAIL reset_chan: got %h expected 00", {mux_sel, result_chan}); end
`endif
        rst_b = 1'b1;
        step();
    endtask

    task automatic test_basic();
        // {seq_init, seq_samp, seq_cmp, seq_logic, busy} for cycles 1..16, L = 13
        logic [4:0]  exp_tab [1:16];
        logic [1:16] comp_bits;
        exp_tab = '{5'b10001, 5'b10001, 5'b01001, 5'b01001, 5'b01001,
                    5'b00101, 5'b00011, 5'b00101, 5'b00011, 5'b00101,
                    5'b00011, 5'b00101, 5'b00011, 5'b00001, 5'b00000, 5'b00000};
        // CMP cycles 6,8,10,12 carry 1,0,1,1; neighbours disagree to expose off-by-one sampling
        comp_bits = 16'b0000011011010000;
        set_std();
        result_ready = 1'b0;
        start = 1'b1; cyc = 0; step(); start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            comp_in = comp_bits[c];
            if (c == 3) begin t_samp = 8'd1; t_cmp = 8'd5; t_logic = 8'd7; n_bits = 5'd9; end
            if (c == 4) start = 1'b1;
            if (c == 5) start = 1'b0;
            n_cmp++; if ({seq_init, seq_samp, seq_cmp, seq_logic, busy} !== exp_tab[c]) begin n_fail++; $display("FAIL basic_phase c=%0d: got %b expected %b", c, {seq_init, seq_samp, seq_cmp, seq_logic, busy}, exp_tab[c]); end
            if (c == 14) begin
                n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %b expected 0", result_valid); end
            end
            if (c == 15) begin
                n_cmp++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", result_valid); end
                n_cmp++; if (result !== 16'h000B) begin n_fail++; $display("FAIL basic_result: got %h expected 000b", result); end
            end
            if (c < 16) step();
        end
        n_cmp++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_hold: got %b expected 1", result_valid); end
        result_ready = 1'b1; step(); result_ready = 1'b0;
        n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL basic_accept: got %b expected 0", result_valid); end
        set_std();
    endtask

    task automatic test_continuous();
        int   rises [$];
        int   busy_cnt;
        int   first_idle;
        logic prev;
        logic ovr_seen;
        busy_cnt = 0; first_idle = -1; prev = 1'b0; ovr_seen = 1'b0;
        set_std();
        comp_in = 1'b1; result_ready = 1'b1; continuous = 1'b1;
        start = 1'b1; cyc = 0; step(); start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (cyc == 35) continuous = 1'b0;
            if (seq_init && !prev) rises.push_back(cyc);
            prev = seq_init;
            if (overrun) ovr_seen = 1'b1;
            if (!busy) begin first_idle = cyc; break; end
            busy_cnt++;
            step();
        end
        n_cmp++; if (rises.size() !== 3) begin n_fail++; $display("FAIL cont_count: got %0d expected 3", rises.size()); end
        if (rises.size() >= 3) begin
            n_cmp++; if (rises[0] !== 1) begin n_fail++; $display("FAIL cont_first: got %0d expected 1", rises[0]); end
            n_cmp++; if (rises[1] - rises[0] !== 14) begin n_fail++; $display("FAIL cont_period1: got %0d expected 14", rises[1] - rises[0]); end
            n_cmp++; if (rises[2] - rises[1] !== 14) begin n_fail++; $display("FAIL cont_period2: got %0d expected 14", rises[2] - rises[1]); end
        end
        n_cmp++; if (busy_cnt !== 42) begin n_fail++; $display("FAIL cont_busy: got %0d expected 42", busy_cnt); end
        n_cmp++; if (first_idle !== 43) begin n_fail++; $display("FAIL cont_idle: got %0d expected 43", first_idle); end
        n_cmp++; if (ovr_seen !== 1'b0) begin n_fail++; $display("FAIL cont_overrun: got %b expected 0", ovr_seen); end
        n_cmp++; if (result !== 16'h000F) begin n_fail++; $display("FAIL cont_result: got %h expected 000f", result); end
        continuous = 1'b0; result_ready = 1'b0;
    endtask

    task automatic test_nbits_clamp();
        logic [4:0] nbl [2];
        int cmp_cnt;
        int busy_cnt;
        nbl = '{5'd0, 5'd20};
        for (int j = 0; j < 2; j++) begin
            t_init = 8'd1; t_samp = 8'd1; t_cmp = 8'd1; t_logic = 8'd1; n_bits = nbl[j];
            comp_in = 1'b1; result_ready = 1'b1;
            cmp_cnt = 0; busy_cnt = 0;
            start = 1'b1; cyc = 0; step(); start = 1'b0;
            for (int k = 0; k < 200; k++) begin
                if (!busy) break;
                if (seq_cmp) cmp_cnt++;
                busy_cnt++;
                step();
            end
            n_cmp++; if (cmp_cnt !== 16) begin n_fail++; $display("FAIL clamp_cmp n=%0d: got %0d expected 16", nbl[j], cmp_cnt); end
            n_cmp++; if (busy_cnt !== 35) begin n_fail++; $display("FAIL clamp_busy n=%0d: got %0d expected 35", nbl[j], busy_cnt); end
            n_cmp++; if (result !== 16'hFFFF) begin n_fail++; $display("FAIL clamp_result n=%0d: got %h expected ffff", nbl[j], result); end
        end
        result_ready = 1'b0;
    endtask

    task automatic test_zero_dur();
        int ci, cs, cc, cl, cb;
        ci = 0; cs = 0; cc = 0; cl = 0; cb = 0;
        t_init = 8'd0; t_samp = 8'd0; t_cmp = 8'd0; t_logic = 8'd0; n_bits = 5'd2;
        comp_in = 1'b1; result_ready = 1'b1;
        start = 1'b1; cyc = 0; step(); start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (!busy) break;
            if (seq_init) ci++;
            if (seq_samp) cs++;
            if (seq_cmp) cc++;
            if (seq_logic) cl++;
            cb++;
            step();
        end
        n_cmp++; if ({ci, cs, cc, cl} !== {32'd1, 32'd1, 32'd2, 32'd2}) begin n_fail++; $display("FAIL zero_phases: got %0d/%0d/%0d/%0d expected 1/1/2/2", ci, cs, cc, cl); end
        n_cmp++; if (cb !== 7) begin n_fail++; $display("FAIL zero_busy: got %0d expected 7", cb); end
        n_cmp++; if (result !== 16'h0003) begin n_fail++; $display("FAIL zero_result: got %h expected 0003", result); end
        result_ready = 1'b0;
        set_std();
    endtask

    task automatic test_overrun();
        result_ready = 1'b1; step(); result_ready = 1'b0;
        n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_pre_valid: got %b expected 0", result_valid); end
        run_std(1'b1, 1'b0);
        n_cmp++; if ({result_valid, overrun, result} !== {2'b10, 16'h000F}) begin n_fail++; $display("FAIL ovr_first: got v=%b o=%b r=%h expected v=1 o=0 r=000f", result_valid, overrun, result); end
        run_std(1'b0, 1'b0);
        n_cmp++; if ({result_valid, overrun, result} !== {2'b11, 16'h0000}) begin n_fail++; $display("FAIL ovr_second: got v=%b o=%b r=%h expected v=1 o=1 r=0000", result_valid, overrun, result); end
        clr_overrun = 1'b1; step(); clr_overrun = 1'b0; step();
        n_cmp++; if ({result_valid, overrun} !== 2'b10) begin n_fail++; $display("FAIL ovr_clear: got v=%b o=%b expected v=1 o=0", result_valid, overrun); end
        run_std(1'b1, 1'b1);
        n_cmp++; if ({overrun, result} !== {1'b1, 16'h000F}) begin n_fail++; $display("FAIL ovr_clr_same: got o=%b r=%h expected o=1 r=000f", overrun, result); end
        clr_overrun = 1'b1; step(); clr_overrun = 1'b0; step();
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear2: got %b expected 0", overrun); end
    endtask

    task automatic test_abort();
        set_std();
        comp_in = 1'b0; result_ready = 1'b0;
        start = 1'b1; cyc = 0; step(); start = 1'b0;
        for (int k = 0; k < 9; k++) step();
        n_cmp++; if (seq_cmp !== 1'b1) begin n_fail++; $display("FAIL abort_in_cmp c=%0d: got %b expected 1", cyc, seq_cmp); end
        abort = 1'b1; step(); abort = 1'b0;
        n_cmp++; if ({seq_init, seq_samp, seq_cmp, seq_logic, busy} !== 5'b00000) begin n_fail++; $display("FAIL abort_outputs: got %b expected 00000", {seq_init, seq_samp, seq_cmp, seq_logic, busy}); end
        n_cmp++; if ({result_valid, result, overrun} !== {1'b1, 16'h000F, 1'b0}) begin n_fail++; $display("FAIL abort_result: got v=%b r=%h o=%b expected v=1 r=000f o=0", result_valid, result, overrun); end
        step(); step();
        n_cmp++; if ({busy, result_valid} !== 2'b01) begin n_fail++; $display("FAIL abort_stays_idle: got busy=%b v=%b expected busy=0 v=1", busy, result_valid); end
        result_ready = 1'b1; step(); result_ready = 1'b0;
    endtask

`ifdef ADC_SEQ_AUTOSCAN_EN
    task automatic test_autoscan();
        logic [3:0] chans [$];
        logic [3:0] exp_ch [4];
        exp_ch = '{4'd0, 4'd2, 4'd15, 4'd0};
        adc_mask = 16'h8005;
        t_init = 8'd1; t_samp = 8'd1; t_cmp = 8'd1; t_logic = 8'd1; n_bits = 5'd1;
        comp_in = 1'b1; result_ready = 1'b1; continuous = 1'b1;
        start = 1'b1; cyc = 0; step(); start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (result_valid && chans.size() < 4) chans.push_back(result_chan);
            if (chans.size() >= 4) continuous = 1'b0;
            if (!busy && chans.size() >= 4) break;
            step();
        end
        n_cmp++; if (chans.size() !== 4) begin n_fail++; $display("FAIL scan_count: got %0d expected 4", chans.size()); end
        for (int i = 0; i < 4 && i < chans.size(); i++) begin
            n_cmp++; if (chans[i] !== exp_ch[i]) begin n_fail++; $display("FAIL scan_chan %0d: got %0d expected %0d", i, chans[i], exp_ch[i]); end
        end
        continuous = 1'b0; result_ready = 1'b0;
        set_std();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_continuous();
        test_nbits_clamp();
        test_zero_dur();
        test_overrun();
        test_abort();
`ifdef ADC_SEQ_AUTOSCAN_EN
        test_autoscan();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
